// File: rtl/segq_pkg.sv
// segq_pkg: shared state, segment record and field widths for the segment queue
package segq_pkg;
    localparam int DIR_W = 2;
    localparam int ACC_W = 32;
    localparam int SAMP_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, ARM, RUN} state_t;
    typedef struct packed {
        logic [DIR_W-1:0] dir;
        logic [ACC_W-1:0] acc;
        logic [SAMP_W-1:0] accel_samples;
        logic [SAMP_W-1:0] cruise_samples;
    } seg_t;
endpackage

// File: rtl/segq_fifo.sv
// segq_fifo: synchronous segment FIFO with wrapping pointers, level count and flush
module segq_fifo import segq_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push_valid,
    input  seg_t push_data,
    input  logic pop,
    output seg_t head,
    output logic [$clog2(DEPTH):0] level,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    seg_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop_ok;
    assign push = push_valid && !full && !flush;
    assign pop_ok = pop && !empty;
    assign head = mem[rd_ptr];
    assign empty = level == '0;
    assign full = level == LW'(DEPTH);
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/segment_queue.sv
// segment_queue: segment FIFO feeding an axis engine over req/ack; SEGQ_UNDERRUN_EN enables the sticky underrun flag
module segment_queue import segq_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic segValid,
    output logic segReady,
    input  logic signed [DIR_W-1:0] segDirection,
    input  logic signed [ACC_W-1:0] segAcceleration,
    input  logic [SAMP_W-1:0] segAccelSamples,
    input  logic [SAMP_W-1:0] segCruiseSamples,
    input  logic flush,
    output logic prgmReq,
    input  logic prgmAck,
    output logic signed [DIR_W-1:0] prgmDirection,
    output logic signed [ACC_W-1:0] prgmAcceleration,
    output logic [SAMP_W-1:0] prgmAccelSamples,
    output logic [SAMP_W-1:0] prgmCruiseSamples,
    input  logic busy,
    output logic [$clog2(DEPTH):0] level,
    output logic empty,
    output logic full,
    output logic active,
    output logic underrun,
    input  logic underrunClear
);
    localparam int CW = $clog2(ARM_TIMEOUT) + 1;
    state_t state;
    seg_t in_seg, head;
    logic [CW-1:0] arm_cnt;
    logic issue;
    assign in_seg = {segDirection, segAcceleration, segAccelSamples, segCruiseSamples};
    assign issue = state == IDLE && !empty && !flush;
    assign segReady = !full;
    assign active = state != IDLE;
    segq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push_valid(segValid),
        .push_data(in_seg),
        .pop(issue),
        .head(head),
        .level(level),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prgmReq <= 1'b0;
            arm_cnt <= '0;
            {prgmDirection, prgmAcceleration, prgmAccelSamples, prgmCruiseSamples} <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state <= REQ;
                    prgmReq <= 1'b1;
                    {prgmDirection, prgmAcceleration, prgmAccelSamples, prgmCruiseSamples} <= head;
                end
                REQ: if (prgmAck) begin
                    state <= ARM;
                    prgmReq <= 1'b0;
                    arm_cnt <= '0;
                end
                // a segment that never raises busy is treated as zero-length
                ARM: if (busy) state <= RUN;
                     else if (arm_cnt == CW'(ARM_TIMEOUT - 1)) state <= IDLE;
                     else arm_cnt <= arm_cnt + CW'(1);
                RUN: if (!busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SEGQ_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) underrun <= 1'b0;
        else if (state == RUN && !busy && empty) underrun <= 1'b1;
        else if (underrunClear) underrun <= 1'b0;
    end
`else
    assign underrun = 1'b0 & underrunClear;
`endif
endmodule

// File: tb/tb_segment_queue.sv
// tb_segment_queue: directed self-checking bench for segment_queue (DEPTH=8, ARM_TIMEOUT=16)
module tb_segment_queue;
    import segq_pkg::*;
`ifdef SEGQ_UNDERRUN_EN
    localparam logic UR = 1'b1;
`else
    localparam logic UR = 1'b0;
`endif
    logic clk = 0, rst = 1, segValid = 0, flush = 0, prgmAck = 0, busy = 0, underrunClear = 0;
    logic signed [1:0] segDirection = 0;
    logic signed [31:0] segAcceleration = 0;
    logic [31:0] segAccelSamples = 0, segCruiseSamples = 0;
    logic segReady, prgmReq, empty, full, active, underrun;
    logic signed [1:0] prgmDirection;
    logic signed [31:0] prgmAcceleration;
    logic [31:0] prgmAccelSamples, prgmCruiseSamples;
    logic [3:0] level;
    int checks = 0, failures = 0;

    segment_queue #(.DEPTH(8), .ARM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .segValid(segValid), .segReady(segReady),
        .segDirection(segDirection), .segAcceleration(segAcceleration),
        .segAccelSamples(segAccelSamples), .segCruiseSamples(segCruiseSamples),
        .flush(flush), .prgmReq(prgmReq), .prgmAck(prgmAck),
        .prgmDirection(prgmDirection), .prgmAcceleration(prgmAcceleration),
        .prgmAccelSamples(prgmAccelSamples), .prgmCruiseSamples(prgmCruiseSamples),
        .busy(busy), .level(level), .empty(empty), .full(full), .active(active),
        .underrun(underrun), .underrunClear(underrunClear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic seg_t mk(input int k);
        return '{dir: 2'(1 + k % 3), acc: 32'(100 + k), accel_samples: 32'(10 + k), cruise_samples: 32'(20 + k)};
    endfunction

    task automatic drive(input logic v, input seg_t s);
        segValid = v;
        {segDirection, segAcceleration, segAccelSamples, segCruiseSamples} = s;
    endtask

    task automatic serve(input seg_t s, input int busy_len, input logic clr);
        int n = 0;
        while (!prgmReq && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", prgmReq, 1);
        check("dir", $unsigned(prgmDirection), s.dir);
        check("acc", prgmAcceleration, s.acc);
        check("ramp", prgmAccelSamples, s.accel_samples);
        check("cruise", prgmCruiseSamples, s.cruise_samples);
        repeat (3) @(negedge clk);
        check("req_hold", prgmReq, 1);
        prgmAck = 1;
        @(negedge clk);
        prgmAck = 0;
        check("req_drop", prgmReq, 0);
        busy = 1;
        repeat (busy_len) @(negedge clk);
        busy = 0;
        underrunClear = clr;
        @(negedge clk);
        underrunClear = 0;
        check("idle_after_run", active, 0);
    endtask

    initial begin
        drive(0, '0);
        repeat (2) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", segReady, 1);
        check("rst_req", prgmReq, 0);
        check("rst_acc", prgmAcceleration, 0);
        check("rst_active", active, 0);
        check("rst_underrun", underrun, 0);
        rst = 0;

        drive(1, mk(0));
        @(negedge clk);
        check("lat_lvl1", level, 1);
        check("lat_req_lo", prgmReq, 0);
        drive(1, mk(1));
        @(negedge clk);
        check("lat_req_hi", prgmReq, 1);
        check("pushpop_lvl", level, 1);
        check("req_active", active, 1);
        drive(1, mk(2));
        @(negedge clk);
        drive(0, '0);
        check("lvl_2", level, 2);
        serve(mk(0), 50, 0);
        check("lvl_after1", level, 2);
        serve(mk(1), 50, 0);
        serve(mk(2), 50, 0);
        check("lvl_drained", level, 0);
        check("empty_drained", empty, 1);
        check("ur_after_drain", underrun, UR);
        underrunClear = 1;
        @(negedge clk);
        underrunClear = 0;
        check("ur_clear", underrun, 0);

        drive(1, mk(10));
        @(negedge clk);
        drive(0, '0);
        @(negedge clk);
        check("full_req", prgmReq, 1);
        check("full_lvl0", level, 0);
        for (int k = 0; k < 8; k++) begin
            drive(1, mk(20 + k));
            @(negedge clk);
        end
        check("full_flag", full, 1);
        check("full_ready", segReady, 0);
        check("full_lvl8", level, 8);
        drive(1, mk(99));
        @(negedge clk);
        drive(0, '0);
        check("full_hold", level, 8);
        serve(mk(10), 2, 0);
        drive(1, mk(77));
        @(negedge clk);
        drive(0, '0);
        check("full_pop_nopush", level, 7);
        check("full_pop_req", prgmReq, 1);
        for (int k = 0; k < 8; k++) serve(mk(20 + k), 2, 0);
        check("wrap_drained", level, 0);
        check("ur_set", underrun, UR);
        underrunClear = 1;
        @(negedge clk);
        underrunClear = 0;
        check("ur_clear2", underrun, 0);
        drive(1, mk(30));
        @(negedge clk);
        drive(0, '0);
        serve(mk(30), 2, 1);
        check("ur_set_wins", underrun, UR);
        underrunClear = 1;
        @(negedge clk);
        underrunClear = 0;

        drive(1, mk(40));
        @(negedge clk);
        drive(1, mk(41));
        @(negedge clk);
        drive(0, '0);
        check("to_req", prgmReq, 1);
        busy = 1;
        @(negedge clk);
        busy = 0;
        check("busy_in_req", prgmReq, 1);
        check("busy_in_req_act", active, 1);
        prgmAck = 1;
        @(negedge clk);
        check("to_arm", active, 1);
        @(negedge clk);
        prgmAck = 0;
        repeat (14) @(negedge clk);
        check("to_arm15", active, 1);
        @(negedge clk);
        check("to_arm16", active, 0);
        check("to_lvl", level, 1);
        @(negedge clk);
        check("to_next_req", prgmReq, 1);
        serve(mk(41), 2, 0);

        for (int k = 0; k < 5; k++) begin
            drive(1, mk(50 + k));
            @(negedge clk);
        end
        check("fl_lvl4", level, 4);
        check("fl_req", prgmReq, 1);
        drive(1, mk(60));
        flush = 1;
        @(negedge clk);
        flush = 0;
        drive(0, '0);
        check("fl_lvl0", level, 0);
        check("fl_empty", empty, 1);
        check("fl_req_held", prgmReq, 1);
        serve(mk(50), 2, 0);
        repeat (5) @(negedge clk);
        check("fl_no_req", prgmReq, 0);
        check("fl_idle", active, 0);

        for (int k = 0; k < 3; k++) begin
            drive(1, mk(70 + k));
            @(negedge clk);
        end
        drive(0, '0);
        check("rs_lvl2", level, 2);
        check("rs_req", prgmReq, 1);
        rst = 1;
        @(negedge clk);
        check("rs_req0", prgmReq, 0);
        check("rs_lvl0", level, 0);
        check("rs_idle", active, 0);
        check("rs_acc0", prgmAcceleration, 0);
        check("rs_empty", empty, 1);
        rst = 0;
        @(negedge clk);
        check("rs_stay", prgmReq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
